// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer
// Takes the wide signed FIR output stream, rounds half-up, arithmetically
// shifts right by Shift, saturates to OutputWidth bits, and queues the result
// in a small FIFO for a valid/ready consumer. It also keeps a sticky drop flag
// and a saturating count of clipped samples for debug.
//
// Pipeline:
//   stage 1 : registered quantized sample and valid bit, loaded on accept
//   stage 2 : FIFO write of the stage-1 sample on the following edge
// inReady reserves FIFO space for the stage-1 sample, so the stage-2 write
// never needs a full check.

`timescale 1ns/1ps

module fir_output_quantizer #(
    parameter int InputWidth  = 38,
    parameter int OutputWidth = 16,
    parameter int Shift       = 15,
    parameter int FifoDepth   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inputValid,
    input  logic [InputWidth-1:0]  din,
    output logic                   inReady,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic [OutputWidth-1:0] dout,
    output logic                   overflow,
    output logic [15:0]            satCount
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;

    // Rounding bias 2^(Shift-1) and the signed clip limits, all held at
    // InputWidth+1 bits so the rounding add cannot wrap.
    localparam logic signed [InputWidth:0] RoundBias =
        {{InputWidth{1'b0}}, 1'b1} << (Shift - 1);
    localparam logic signed [InputWidth:0] MaxOut =
        {{(InputWidth - OutputWidth + 2){1'b0}}, {(OutputWidth - 1){1'b1}}};
    localparam logic signed [InputWidth:0] MinOut =
        {{(InputWidth - OutputWidth + 2){1'b1}}, {(OutputWidth - 1){1'b0}}};
    localparam logic [OutputWidth-1:0] SatHi = {1'b0, {(OutputWidth - 1){1'b1}}};
    localparam logic [OutputWidth-1:0] SatLo = {1'b1, {(OutputWidth - 1){1'b0}}};
    localparam logic [CntW:0]          DepthLimit = (CntW + 1)'(FifoDepth);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                   s1_valid_q, s1_valid_d;
    logic [OutputWidth-1:0] s1_data_q,  s1_data_d;
    logic [PtrW-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q,   rd_ptr_d;
    logic [CntW-1:0]        count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            sat_cnt_q,  sat_cnt_d;
    logic [OutputWidth-1:0] mem_q [FifoDepth];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic signed [InputWidth:0] sum;
    logic signed [InputWidth:0] shifted;
    logic [OutputWidth-1:0]     result;
    logic                       sat;
    logic [CntW:0]              occupancy;
    logic                       accept;
    logic                       push;
    logic                       pop;

    // Round half-up, floor-shift, then clip to the signed output range.
    // NOTE: every always_comb output gets a value on every path (here via the
    // defaults at the top); a missing assignment on any branch infers a latch.
    always_comb begin
        result  = '0;
        sat     = 1'b0;
        sum     = $signed({din[InputWidth-1], din}) + RoundBias;
        shifted = sum >>> Shift;
        if (shifted > MaxOut) begin
            result = SatHi;
            sat    = 1'b1;
        end else if (shifted < MinOut) begin
            result = SatLo;
            sat    = 1'b1;
        end else begin
            result = shifted[OutputWidth-1:0];
        end
    end

    // Space check from registered state only: FIFO entries plus the sample
    // already sitting in stage 1 must leave room for one more.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CntW{1'b0}}, s1_valid_q};
        inReady   = occupancy < DepthLimit;
    end

    // Handshake decode and next-state computation for all control registers.
    always_comb begin
        accept     = inputValid & inReady;
        push       = s1_valid_q;
        pop        = outputValid & outputReady;

        s1_valid_d = accept;
        s1_data_d  = accept ? result : s1_data_q;

        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        overflow_d = overflow_q | (inputValid & ~inReady);

        sat_cnt_d  = sat_cnt_q;
        if (accept && sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Control and stage-1 registers with asynchronous active-low clear.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // FIFO storage: stage-1 sample written on the edge after it was accepted.
    // NOTE: the storage is cleared on reset so dout reads zero out of reset;
    // only a few flops, and it keeps dout free of X before the first write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    // Consumer side and status are pure functions of registered state.
    always_comb begin
        outputValid = (count_q != '0);
        dout        = mem_q[rd_ptr_q];
        overflow    = overflow_q;
        satCount    = sat_cnt_q;
    end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb_fir_output_quantizer
// Directed bench for fir_output_quantizer. A transaction-level model (queue of
// accepted samples, each tagged with whether it has reached the FIFO yet) is
// compared with the DUT on every falling edge; hand-computed literals pin both
// the quantizer function and the observed output streams.

`timescale 1ns/1ps

module tb_fir_output_quantizer;

    localparam int IW    = 38;
    localparam int OW    = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inputValid;
    logic [IW-1:0] din;
    logic          inReady;
    logic          outputValid;
    logic          outputReady;
    logic [OW-1:0] dout;
    logic          overflow;
    logic [15:0]   satCount;

    fir_output_quantizer #(
        .InputWidth (IW),
        .OutputWidth(OW),
        .Shift      (SHIFT),
        .FifoDepth  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inputValid (inputValid),
        .din        (din),
        .inReady    (inReady),
        .outputValid(outputValid),
        .outputReady(outputReady),
        .dout       (dout),
        .overflow   (overflow),
        .satCount   (satCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden quantizer: floor((d + 2^(SHIFT-1)) / 2^SHIFT), clipped to OW bits.
    function automatic void quant(input logic [IW-1:0] d, output longint v, output bit s);
        longint x;
        longint q;
        longint hi;
        longint lo;
        x  = longint'($signed(d));
        q  = (x + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        s  = 1'b0;
        v  = q;
        if (q > hi) begin
            v = hi;
            s = 1'b1;
        end else if (q < lo) begin
            v = lo;
            s = 1'b1;
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: every accepted-but-not-consumed sample, oldest first
    // ------------------------------------------------------------------
    typedef struct {
        longint val;
        bit     in_fifo;
    } ent_t;

    ent_t   sb[$];
    bit     model_ov  = 1'b0;
    int     model_sat = 0;
    longint got[$];

    task automatic model_step();
        bit     do_pop;
        bit     do_acc;
        longint v;
        bit     s;
        do_pop = outputReady && (sb.size() > 0) && sb[0].in_fifo;
        do_acc = inputValid && (sb.size() < DEPTH);
        if (inputValid && !do_acc) model_ov = 1'b1;
        foreach (sb[i]) sb[i].in_fifo = 1'b1;
        if (do_acc) begin
            quant(din, v, s);
            sb.push_back('{val: v, in_fifo: 1'b0});
            if (s && model_sat < 65535) model_sat++;
        end
        if (do_pop) void'(sb.pop_front());
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb.delete();
            model_ov  = 1'b0;
            model_sat = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, plus capture of consumed samples.
    always @(negedge clk) begin
        bit exp_valid;
        if (chk_en) begin
            exp_valid = (sb.size() > 0) && sb[0].in_fifo;
            check("cyc_inReady", longint'(inReady), longint'(sb.size() < DEPTH));
            check("cyc_outputValid", longint'(outputValid), longint'(exp_valid));
            if (exp_valid) check("cyc_dout", longint'($signed(dout)), sb[0].val);
            check("cyc_overflow", longint'(overflow), longint'(model_ov));
            check("cyc_satCount", longint'(satCount), longint'(model_sat));
        end
        if (rst && outputValid && outputReady) got.push_back(longint'($signed(dout)));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic drive(input bit v, input longint d, input bit r);
        @(posedge clk);
        #1;
        inputValid  = v;
        din         = IW'(d);
        outputReady = r;
    endtask

    task automatic check_got(input string name, input longint exp[$]);
        check({name, "_count"}, longint'(got.size()), longint'(exp.size()));
        foreach (exp[i]) begin
            if (i < got.size()) check(name, got[i], exp[i]);
        end
    endtask

    longint rnd_in [5] = '{32768, 16384, 16383, -16384, -16385};
    longint rnd_out[5] = '{1, 1, 0, 0, -1};
    longint exp_q[$];
    longint pv;
    bit     ps;

    initial begin
        rst         = 1'b0;
        inputValid  = 1'b0;
        din         = '0;
        outputReady = 1'b0;

        // Model pinning against hand-computed values
        quant(IW'(longint'(32768)), pv, ps);
        check("pin_q_32768", pv, 1);
        quant(IW'(longint'(-16385)), pv, ps);
        check("pin_q_m16385", pv, -1);
        quant(IW'((longint'(1) << 37) - 1), pv, ps);
        check("pin_q_max", pv, 32767);
        check("pin_sat_max", longint'(ps), 1);
        quant(IW'(longint'(32767) * 32768 + 16384), pv, ps);
        check("pin_q_edge_up", pv, 32767);
        check("pin_sat_edge_up", longint'(ps), 1);

        // Reset state
        #12;
        check("rst_inReady", longint'(inReady), 1);
        check("rst_outputValid", longint'(outputValid), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_satCount", longint'(satCount), 0);
        check("rst_dout", longint'(dout), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;

        // Rounding with an explicit two-cycle latency check on the first sample
        got.delete();
        drive(1, rnd_in[0], 1);
        drive(0, 0, 1);
        @(negedge clk);
        check("lat_stage1_valid", longint'(outputValid), 0);
        @(negedge clk);
        check("lat_fifo_valid", longint'(outputValid), 1);
        check("lat_fifo_dout", longint'($signed(dout)), 1);
        for (int i = 1; i < 5; i++) begin
            drive(1, rnd_in[i], 1);
            repeat (3) drive(0, 0, 1);
        end
        repeat (3) drive(0, 0, 1);
        exp_q = '{};
        foreach (rnd_out[i]) exp_q.push_back(rnd_out[i]);
        check_got("round_seq", exp_q);
        check("round_satCount", longint'(satCount), 0);

        // Saturation
        got.delete();
        drive(1, (longint'(1) << 37) - 1, 1);
        repeat (3) drive(0, 0, 1);
        drive(1, -(longint'(1) << 37), 1);
        repeat (3) drive(0, 0, 1);
        drive(1, longint'(32767) * 32768, 1);
        repeat (4) drive(0, 0, 1);
        check_got("sat_seq", '{32767, -32768, 32767});
        check("sat_satCount", longint'(satCount), 2);

        // Backpressure: six strobes into a stalled consumer
        got.delete();
        drive(0, 0, 0);
        for (int k = 1; k <= 6; k++) drive(1, longint'(k) * 32768, 0);
        repeat (2) drive(0, 0, 0);
        @(negedge clk);
        check("full_inReady", longint'(inReady), 0);
        check("full_overflow", longint'(overflow), 1);
        check("full_valid", longint'(outputValid), 1);
        check("full_dout_head", longint'($signed(dout)), 1);
        repeat (10) drive(0, 0, 1);
        check_got("full_drain", '{1, 2, 3, 4});
        check("drain_overflow", longint'(overflow), 1);
        check("drain_valid", longint'(outputValid), 0);

        // Asynchronous reset with three samples queued
        got.delete();
        for (int k = 7; k <= 9; k++) drive(1, longint'(k) * 32768, 0);
        repeat (3) drive(0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_outputValid", longint'(outputValid), 0);
        check("arst_inReady", longint'(inReady), 1);
        check("arst_overflow", longint'(overflow), 0);
        check("arst_satCount", longint'(satCount), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) drive(0, 0, 1);
        check("arst_nothing_out", longint'(got.size()), 0);

        // Concurrent push/pop across pointer wrap
        got.delete();
        drive(1, longint'(50) * 32768, 0);
        drive(1, longint'(51) * 32768, 0);
        repeat (3) drive(0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, longint'(100 + i) * 32768, 1);
        repeat (8) drive(0, 0, 1);
        exp_q = '{50, 51};
        for (int i = 0; i < 20; i++) exp_q.push_back(longint'(100 + i));
        check_got("conc_seq", exp_q);
        check("conc_overflow", longint'(overflow), 0);

        // FIR-paced random stream with random consumer readiness
        got.delete();
        exp_q = '{};
        for (int n = 0; n < 500; n++) begin
            longint d;
            logic [IW-1:0] raw;
            raw = IW'({$urandom, $urandom});
            d   = longint'($signed(raw));
            if ($urandom_range(0, 3) != 0) d = d >>> $urandom_range(8, 30);
            quant(IW'(d), pv, ps);
            exp_q.push_back(pv);
            for (int j = 0; j < 70; j++) drive(j == 0, d, 1'($urandom_range(0, 1)));
        end
        repeat (10) drive(0, 0, 1);
        check_got("pace_seq", exp_q);
        check("pace_overflow", longint'(overflow), 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
